// File: rtl/microcode_sequencer.sv
// SAP-1.5 fetch/execute sequencer: T-state FSM with strobes decoded from the registered state and the live opcode and flags.
// Optional build macro SINGLE_STEP_EN adds step_mode/step_pulse for one-instruction-per-pulse stepping.
module microcode_sequencer #(
  parameter int OPCODE_WIDTH = 4,
  parameter int FIXED_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    flag_carry,
  input  logic                    flag_zero,
`ifdef SINGLE_STEP_EN
  input  logic                    step_mode,
  input  logic                    step_pulse,
`endif
  output logic [2:0]              bus_src,
  output logic                    load_mar,
  output logic                    load_ir,
  output logic                    load_a,
  output logic                    load_b,
  output logic                    load_out,
  output logic                    load_pc,
  output logic                    load_flags,
  output logic                    ram_we,
  output logic                    pc_inc,
  output logic                    alu_sub,
  output logic                    halted,
  output logic [2:0]              t_state
);

  typedef enum logic [2:0] {
    ST_F0   = 3'd0,
    ST_F1   = 3'd1,
    ST_E0   = 3'd2,
    ST_E1   = 3'd3,
    ST_E2   = 3'd4,
    ST_HALT = 3'd7
  } state_e;

  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDB = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_STA = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_JC  = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OP_OUT = OPCODE_WIDTH'(14);
  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(15);

  state_e state_q, state_d;
  // run_q keeps F0 silent until the first rising edge after reset release
  logic   run_q;
  logic   step_hold;
  logic   is_mem, is_alu, is_hlt, last_step;

`ifdef SINGLE_STEP_EN
  assign step_hold = step_mode && !step_pulse;
`else
  assign step_hold = 1'b0;
`endif

  assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign is_mem = is_alu || (opcode == OP_LDA) || (opcode == OP_LDB) || (opcode == OP_STA);
  assign is_hlt = (opcode == OP_HLT);

  always_comb begin
    last_step = 1'b1;
    if (FIXED_CYCLES != 0) begin
      last_step = (state_q == ST_E2);
    end else begin
      case (state_q)
        ST_E0:   last_step = !is_mem;
        ST_E1:   last_step = !is_alu;
        default: last_step = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_F0:   if (run_q && !step_hold) state_d = ST_F1;
      ST_F1:   state_d = ST_E0;
      ST_E0, ST_E1, ST_E2: begin
        if (last_step)               state_d = is_hlt ? ST_HALT : ST_F0;
        else if (state_q == ST_E0)   state_d = ST_E1;
        else                         state_d = ST_E2;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_F0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_F0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  assign t_state = state_q;
  assign halted  = (state_q == ST_HALT);

  always_comb begin
    bus_src    = 3'd0;
    load_mar   = 1'b0;
    load_ir    = 1'b0;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_out   = 1'b0;
    load_pc    = 1'b0;
    load_flags = 1'b0;
    ram_we     = 1'b0;
    pc_inc     = 1'b0;
    alu_sub    = 1'b0;
    case (state_q)
      ST_F0: if (run_q && !step_hold) begin
        bus_src  = 3'd1;
        load_mar = 1'b1;
      end
      ST_F1: begin
        bus_src = 3'd2;
        load_ir = 1'b1;
        pc_inc  = 1'b1;
      end
      ST_E0: begin
        if (is_mem) begin
          bus_src  = 3'd3;
          load_mar = 1'b1;
        end else if (opcode == OP_LDI) begin
          bus_src = 3'd3;
          load_a  = 1'b1;
        end else if ((opcode == OP_JMP) || ((opcode == OP_JC) && flag_carry) ||
                     ((opcode == OP_JZ) && flag_zero)) begin
          bus_src = 3'd3;
          load_pc = 1'b1;
        end else if (opcode == OP_OUT) begin
          bus_src  = 3'd5;
          load_out = 1'b1;
        end
      end
      ST_E1: begin
        if (opcode == OP_LDA) begin
          bus_src = 3'd2;
          load_a  = 1'b1;
        end else if ((opcode == OP_LDB) || is_alu) begin
          bus_src = 3'd2;
          load_b  = 1'b1;
        end else if (opcode == OP_STA) begin
          // RAM is written from A, so the bus is never sourced by RAM here
          bus_src = 3'd5;
          ram_we  = 1'b1;
        end
      end
      ST_E2: if (is_alu) begin
        bus_src    = 3'd4;
        load_a     = 1'b1;
        load_flags = 1'b1;
        alu_sub    = (opcode == OP_SUB);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: per-cycle expected output vectors are queued, then popped and checked mid-cycle.
module tb_microcode_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] opcode = 4'h6;
  logic       flag_carry = 1'b0;
  logic       flag_zero = 1'b0;
  logic       step_mode = 1'b0;
  logic       step_pulse = 1'b0;

  logic [2:0] bus_v, bus_f, ts_v, ts_f;
  logic mar_v, ir_v, a_v, b_v, out_v, pc_v, flg_v, we_v, inc_v, sub_v, hlt_v;
  logic mar_f, ir_f, a_f, b_f, out_f, pc_f, flg_f, we_f, inc_f, sub_f, hlt_f;

  always #5 clk = ~clk;

  microcode_sequencer #(.OPCODE_WIDTH(4), .FIXED_CYCLES(0)) u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .flag_carry(flag_carry), .flag_zero(flag_zero),
`ifdef SINGLE_STEP_EN
    .step_mode(step_mode), .step_pulse(step_pulse),
`endif
    .bus_src(bus_v), .load_mar(mar_v), .load_ir(ir_v), .load_a(a_v), .load_b(b_v),
    .load_out(out_v), .load_pc(pc_v), .load_flags(flg_v), .ram_we(we_v), .pc_inc(inc_v),
    .alu_sub(sub_v), .halted(hlt_v), .t_state(ts_v)
  );

  microcode_sequencer #(.OPCODE_WIDTH(4), .FIXED_CYCLES(1)) u_fix (
    .clk(clk), .reset(reset), .opcode(opcode), .flag_carry(flag_carry), .flag_zero(flag_zero),
`ifdef SINGLE_STEP_EN
    .step_mode(step_mode), .step_pulse(step_pulse),
`endif
    .bus_src(bus_f), .load_mar(mar_f), .load_ir(ir_f), .load_a(a_f), .load_b(b_f),
    .load_out(out_f), .load_pc(pc_f), .load_flags(flg_f), .ram_we(we_f), .pc_inc(inc_f),
    .alu_sub(sub_f), .halted(hlt_f), .t_state(ts_f)
  );

  // {halted, t_state, bus_src, mar, ir, a, b, out, pc, flags, we, inc, sub}
  logic [16:0] obs_v, obs_f;
  assign obs_v = {hlt_v, ts_v, bus_v, mar_v, ir_v, a_v, b_v, out_v, pc_v, flg_v, we_v, inc_v, sub_v};
  assign obs_f = {hlt_f, ts_f, bus_f, mar_f, ir_f, a_f, b_f, out_f, pc_f, flg_f, we_f, inc_f, sub_f};

  localparam logic [9:0] S_NONE = 10'b0;
  localparam logic [9:0] S_MAR  = 10'b10_0000_0000;
  localparam logic [9:0] S_IR   = 10'b01_0000_0000;
  localparam logic [9:0] S_A    = 10'b00_1000_0000;
  localparam logic [9:0] S_B    = 10'b00_0100_0000;
  localparam logic [9:0] S_OUT  = 10'b00_0010_0000;
  localparam logic [9:0] S_PC   = 10'b00_0001_0000;
  localparam logic [9:0] S_FLG  = 10'b00_0000_1000;
  localparam logic [9:0] S_WE   = 10'b00_0000_0100;
  localparam logic [9:0] S_INC  = 10'b00_0000_0010;
  localparam logic [9:0] S_SUB  = 10'b00_0000_0001;

  typedef struct {
    string       tag;
    bit          fix;
    logic [16:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  failures = 0;

  function automatic logic [16:0] ev(input logic h, input logic [2:0] t, input logic [2:0] b,
                                     input logic [9:0] s);
    return {h, t, b, s};
  endfunction

  task automatic push(input string tag, input bit fix, input logic [16:0] e);
    sb_t item;
    item.tag = tag;
    item.fix = fix;
    item.exp = e;
    sb_q.push_back(item);
  endtask

  task automatic check_now();
    sb_t item;
    logic [16:0] got;
    item = sb_q.pop_front();
    got = item.fix ? obs_f : obs_v;
    checks++;
    assert (got === item.exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", item.tag, got, item.exp);
    end
  endtask

  // One queued entry per cycle, compared 1ns after the falling edge.
  task automatic drain();
    while (sb_q.size() > 0) begin
      #1;
      check_now();
      @(negedge clk);
    end
  endtask

  task automatic push_fetch(input string tag, input bit fix);
    push({tag, "_F0"}, fix, ev(1'b0, 3'd0, 3'd1, S_MAR));
    push({tag, "_F1"}, fix, ev(1'b0, 3'd1, 3'd2, S_IR | S_INC));
  endtask

  task automatic reset_and_release();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    push("reset_idle", 1'b0, ev(1'b0, 3'd0, 3'd0, S_NONE));
    drain();
    reset = 1'b1;
    @(negedge clk);

    opcode = 4'h6;
    push_fetch("ldi", 1'b0);
    push("ldi_E0", 1'b0, ev(1'b0, 3'd2, 3'd3, S_A));
    drain();

    opcode = 4'h3;
    push_fetch("add", 1'b0);
    push("add_E0", 1'b0, ev(1'b0, 3'd2, 3'd3, S_MAR));
    push("add_E1", 1'b0, ev(1'b0, 3'd3, 3'd2, S_B));
    push("add_E2", 1'b0, ev(1'b0, 3'd4, 3'd4, S_A | S_FLG));
    drain();

    opcode = 4'h4;
    push_fetch("sub", 1'b0);
    push("sub_E0", 1'b0, ev(1'b0, 3'd2, 3'd3, S_MAR));
    push("sub_E1", 1'b0, ev(1'b0, 3'd3, 3'd2, S_B));
    push("sub_E2", 1'b0, ev(1'b0, 3'd4, 3'd4, S_A | S_FLG | S_SUB));
    drain();

    opcode = 4'h1;
    push_fetch("lda", 1'b0);
    push("lda_E0", 1'b0, ev(1'b0, 3'd2, 3'd3, S_MAR));
    push("lda_E1", 1'b0, ev(1'b0, 3'd3, 3'd2, S_A));
    drain();

    opcode = 4'h2;
    push_fetch("ldb", 1'b0);
    push("ldb_E0", 1'b0, ev(1'b0, 3'd2, 3'd3, S_MAR));
    push("ldb_E1", 1'b0, ev(1'b0, 3'd3, 3'd2, S_B));
    drain();

    opcode = 4'h5;
    push_fetch("sta", 1'b0);
    push("sta_E0", 1'b0, ev(1'b0, 3'd2, 3'd3, S_MAR));
    push("sta_E1", 1'b0, ev(1'b0, 3'd3, 3'd5, S_WE));
    drain();

    opcode = 4'h7;
    push_fetch("jmp", 1'b0);
    push("jmp_E0", 1'b0, ev(1'b0, 3'd2, 3'd3, S_PC));
    drain();

    opcode = 4'h8; flag_carry = 1'b0; flag_zero = 1'b1;
    push_fetch("jc0", 1'b0);
    push("jc0_E0", 1'b0, ev(1'b0, 3'd2, 3'd0, S_NONE));
    drain();
    flag_carry = 1'b1; flag_zero = 1'b0;
    push_fetch("jc1", 1'b0);
    push("jc1_E0", 1'b0, ev(1'b0, 3'd2, 3'd3, S_PC));
    drain();

    opcode = 4'h9;
    push_fetch("jz0", 1'b0);
    push("jz0_E0", 1'b0, ev(1'b0, 3'd2, 3'd0, S_NONE));
    drain();
    flag_carry = 1'b0; flag_zero = 1'b1;
    push_fetch("jz1", 1'b0);
    push("jz1_E0", 1'b0, ev(1'b0, 3'd2, 3'd3, S_PC));
    drain();

    opcode = 4'hE;
    push_fetch("out", 1'b0);
    push("out_E0", 1'b0, ev(1'b0, 3'd2, 3'd5, S_OUT));
    drain();

    opcode = 4'hA;
    push_fetch("nop", 1'b0);
    push("nop_E0", 1'b0, ev(1'b0, 3'd2, 3'd0, S_NONE));
    drain();

    // asynchronous reset in the middle of ADD's E1
    opcode = 4'h3;
    push_fetch("abort", 1'b0);
    push("abort_E0", 1'b0, ev(1'b0, 3'd2, 3'd3, S_MAR));
    drain();
    #1;
    push("abort_E1", 1'b0, ev(1'b0, 3'd3, 3'd2, S_B));
    check_now();
    #1 reset = 1'b0;
    #1;
    push("abort_rst", 1'b0, ev(1'b0, 3'd0, 3'd0, S_NONE));
    check_now();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    opcode = 4'h6;
    push_fetch("post_rst", 1'b0);
    push("post_rst_E0", 1'b0, ev(1'b0, 3'd2, 3'd3, S_A));
    drain();

    opcode = 4'hF;
    push_fetch("hlt", 1'b0);
    push("hlt_E0", 1'b0, ev(1'b0, 3'd2, 3'd0, S_NONE));
    drain();
    for (int i = 0; i < 20; i++) begin
      opcode = 4'(i);
      flag_carry = i[0];
      flag_zero = i[1];
      push($sformatf("halt_%0d", i), 1'b0, ev(1'b1, 3'd7, 3'd0, S_NONE));
      #1;
      check_now();
      @(negedge clk);
    end
    #1 reset = 1'b0;
    #1;
    push("halt_rst", 1'b0, ev(1'b0, 3'd0, 3'd0, S_NONE));
    check_now();
    @(negedge clk);

    // fixed-length instance: every instruction occupies F0..E2
    reset = 1'b1;
    @(negedge clk);
    opcode = 4'h6;
    push_fetch("fix_ldi", 1'b1);
    push("fix_ldi_E0", 1'b1, ev(1'b0, 3'd2, 3'd3, S_A));
    push("fix_ldi_E1", 1'b1, ev(1'b0, 3'd3, 3'd0, S_NONE));
    push("fix_ldi_E2", 1'b1, ev(1'b0, 3'd4, 3'd0, S_NONE));
    drain();
    opcode = 4'hA;
    push_fetch("fix_nop", 1'b1);
    push("fix_nop_E0", 1'b1, ev(1'b0, 3'd2, 3'd0, S_NONE));
    push("fix_nop_E1", 1'b1, ev(1'b0, 3'd3, 3'd0, S_NONE));
    push("fix_nop_E2", 1'b1, ev(1'b0, 3'd4, 3'd0, S_NONE));
    push("fix_next_F0", 1'b1, ev(1'b0, 3'd0, 3'd1, S_MAR));
    drain();

`ifdef SINGLE_STEP_EN
    step_mode = 1'b1;
    reset_and_release();
    opcode = 4'h6;
    for (int i = 0; i < 3; i++)
      push($sformatf("step_hold_%0d", i), 1'b0, ev(1'b0, 3'd0, 3'd0, S_NONE));
    drain();
    step_pulse = 1'b1;
    push("step_F0", 1'b0, ev(1'b0, 3'd0, 3'd1, S_MAR));
    #1;
    check_now();
    @(negedge clk);
    step_pulse = 1'b0;
    push("step_F1", 1'b0, ev(1'b0, 3'd1, 3'd2, S_IR | S_INC));
    push("step_E0", 1'b0, ev(1'b0, 3'd2, 3'd3, S_A));
    push("step_hold_after", 1'b0, ev(1'b0, 3'd0, 3'd0, S_NONE));
    push("step_hold_after2", 1'b0, ev(1'b0, 3'd0, 3'd0, S_NONE));
    drain();
    step_mode = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
